// File: rtl/wb2mem_pkg.sv
// Shared types for the wb2mem bridge: mem-interface request and response payloads.
//   mem_req_t  : req_type, req_paddr, req_data, req_mask (bridge -> mem slave)
//   mem_resp_t : resp_type, resp_data                     (mem slave -> bridge)
package wb2mem_pkg;

   localparam int unsigned MEM_AW = 32;
   localparam int unsigned MEM_DW = 32;
   localparam int unsigned MEM_DM = MEM_DW / 8;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } mem_req_type_e;

   typedef enum logic {
      RESP_READ  = 1'b0,
      RESP_WRITE = 1'b1
   } mem_resp_type_e;

   typedef struct packed {
      mem_req_type_e       req_type;
      logic [MEM_AW-1:0]   req_paddr;
      logic [MEM_DW-1:0]   req_data;
      logic [MEM_DM-1:0]   req_mask;
   } mem_req_t;

   typedef struct packed {
      mem_resp_type_e      resp_type;
      logic [MEM_DW-1:0]   resp_data;
   } mem_resp_t;

endpackage

// File: rtl/wb2mem.sv
// wb2mem: Wishbone classic slave that turns each single Wishbone cycle into one
// mem_req / mem_resp transaction. One transaction outstanding, no pipelining.
// A response timeout returns wb_err_o instead of hanging the bus.
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i       : Wishbone cycle, strobe, write enable
//   wb_addr_i/data_i/sel_i    : Wishbone address, write data, byte selects
//   wb_ack_o/err_o            : one-cycle acknowledge / timeout error pulses
//   wb_data_o                 : read data (updated by read responses only)
//   mem_req_valid/ready, mem_req    : request channel toward the mem slave
//   mem_resp_valid/ready, mem_resp  : response channel from the mem slave
module wb2mem
   import wb2mem_pkg::*;
#(
   parameter int unsigned N_AW    = 32,
   parameter int unsigned N_DW    = 32,
   parameter int unsigned N_DM    = N_DW / 8,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [N_AW-1:0] wb_addr_i,
   input  logic [N_DW-1:0] wb_data_i,
   input  logic [N_DM-1:0] wb_sel_i,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic [N_DW-1:0] wb_data_o,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output mem_req_t        mem_req,
   input  logic            mem_resp_valid,
   output logic            mem_resp_ready,
   input  mem_resp_t       mem_resp
);

   // Counter holds 0..TIMEOUT and saturates instead of wrapping.
   localparam int unsigned     CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      RESP  = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             abort_q, abort_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_req_t         req_q, req_d;
   logic [N_DW-1:0]  rdata_q, rdata_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             req_valid_q, req_valid_d;
   logic             resp_ready_q, resp_ready_d;

   // Abort applies as soon as cyc drops, including the cycle the response lands.
   logic abort_c;
   assign abort_c = abort_q | ~wb_cyc_i;

   // Response type is carried by the mem interface but has no meaning here.
   logic resp_type_unused;
   assign resp_type_unused = mem_resp.resp_type;

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         abort_q      <= 1'b0;
         cnt_q        <= '0;
         req_q        <= '0;
         rdata_q      <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         abort_q      <= abort_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         req_valid_q  <= req_valid_d;
         resp_ready_q <= resp_ready_d;
      end
   end

   // Next state; outputs are decoded from the next state so they come out of flops.
   always_comb begin
      state_d = state_q;
      abort_d = abort_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               req_d.req_type  = wb_we_i ? REQ_WRITE : REQ_READ;
               req_d.req_paddr = MEM_AW'(wb_addr_i);
               req_d.req_data  = MEM_DW'(wb_data_i);
               req_d.req_mask  = MEM_DM'(wb_sel_i);
               state_d         = REQ;
            end
         end

         REQ: begin
            if (!wb_cyc_i) begin
               abort_d = 1'b1;
            end
            if (req_valid_q && mem_req_ready) begin
               cnt_d   = '0;
               state_d = RESP;
            end
         end

         RESP: begin
            if (!wb_cyc_i) begin
               abort_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // A response in the timeout cycle takes priority over the error.
            if (mem_resp_valid) begin
               if (req_q.req_type == REQ_READ) begin
                  rdata_d = N_DW'(mem_resp.resp_data);
               end
               state_d = abort_c ? IDLE : ACK;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               // Counter reaches TIMEOUT on this edge.
               err_d   = ~abort_c;
               state_d = DRAIN;
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         DRAIN: begin
            if (mem_resp_valid) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == IDLE) begin
         abort_d = 1'b0;
      end

      ack_d        = (state_d == ACK);
      req_valid_d  = (state_d == REQ);
      resp_ready_d = (state_d == RESP) || (state_d == DRAIN);
   end

   assign wb_ack_o       = ack_q;
   assign wb_err_o       = err_q;
   assign wb_data_o      = rdata_q;
   assign mem_req_valid  = req_valid_q;
   assign mem_req        = req_q;
   assign mem_resp_ready = resp_ready_q;

endmodule

// File: tb/tb_wb2mem.sv
// Directed bench for wb2mem with a scoreboard: stimulus pushes expected mem
// requests and Wishbone terminations; a negedge monitor pops and compares.
module tb_wb2mem;
   import wb2mem_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_addr_i, wb_data_i;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o, wb_err_o;
   logic [31:0] wb_data_o;
   logic        mem_req_valid, mem_req_ready;
   mem_req_t    mem_req;
   logic        mem_resp_valid, mem_resp_ready;
   mem_resp_t   mem_resp;

   always #5 clk = ~clk;

   wb2mem #(.N_AW(32), .N_DW(32), .N_DM(4), .TIMEOUT(8)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .wb_cyc_i       (wb_cyc_i),
      .wb_stb_i       (wb_stb_i),
      .wb_we_i        (wb_we_i),
      .wb_addr_i      (wb_addr_i),
      .wb_data_i      (wb_data_i),
      .wb_sel_i       (wb_sel_i),
      .wb_ack_o       (wb_ack_o),
      .wb_err_o       (wb_err_o),
      .wb_data_o      (wb_data_o),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req        (mem_req),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp       (mem_resp)
   );

   typedef struct {
      logic        err;
      logic [31:0] data;
   } wb_exp_t;

   mem_req_t exp_req_q[$];
   wb_exp_t  exp_wb_q[$];
   int       n_vec = 0;
   int       n_err = 0;

   // Mem slave behaviour knobs.
   int          cfg_ready_delay = 0;
   int          cfg_resp_delay  = 0;
   logic [31:0] cfg_rdata       = '0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Mem slave: ready after cfg_ready_delay cycles of valid, response
   // cfg_resp_delay cycles after the request handshake.
   initial begin
      logic hs_req, hs_rsp, pending;
      int   rdy_cnt, rc;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp       = '0;
      pending        = 1'b0;
      rdy_cnt        = 0;
      rc             = 0;
      forever begin
         @(negedge clk);
         hs_req = mem_req_valid && mem_req_ready;
         hs_rsp = mem_resp_valid && mem_resp_ready;
         @(posedge clk);
         #1;
         if (!rstn) begin
            pending        = 1'b0;
            rc             = 0;
            rdy_cnt        = 0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
         end else begin
            if (hs_rsp) begin
               pending        = 1'b0;
               mem_resp_valid = 1'b0;
            end
            if (hs_req) begin
               pending = 1'b1;
               rc      = 0;
            end
            if (mem_req_valid) rdy_cnt++;
            else               rdy_cnt = 0;
            mem_req_ready = (rdy_cnt > cfg_ready_delay);
            if (pending) begin
               rc++;
               mem_resp_valid     = (rc > cfg_resp_delay);
               mem_resp.resp_data = cfg_rdata;
               mem_resp.resp_type = RESP_WRITE;
            end
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rstn) begin
         if (mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_req: got paddr %0h, required no request", mem_req.req_paddr);
            end else begin
               mem_req_t e;
               e = exp_req_q.pop_front();
               check("req_type",  mem_req.req_type,  e.req_type);
               check("req_paddr", mem_req.req_paddr, e.req_paddr);
               check("req_data",  mem_req.req_data,  e.req_data);
               check("req_mask",  mem_req.req_mask,  e.req_mask);
            end
         end
         if (wb_ack_o || wb_err_o) begin
            check("ack_err_exclusive", wb_ack_o & wb_err_o, 0);
            if (exp_wb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_term: got ack=%0b err=%0b, required none", wb_ack_o, wb_err_o);
            end else begin
               wb_exp_t w;
               w = exp_wb_q.pop_front();
               check("term_is_err", wb_err_o, w.err);
               if (!w.err) check("wb_data_o", wb_data_o, w.data);
            end
         end
      end
   end

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
      mem_req_t r;
      wb_cyc_i    = 1'b1;
      wb_stb_i    = 1'b1;
      wb_we_i     = we;
      wb_addr_i   = addr;
      wb_data_i   = data;
      wb_sel_i    = sel;
      r.req_type  = we ? REQ_WRITE : REQ_READ;
      r.req_paddr = addr;
      r.req_data  = data;
      r.req_mask  = sel;
      exp_req_q.push_back(r);
   endtask

   task automatic release_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic expect_wb(input logic err, input logic [31:0] data);
      wb_exp_t w;
      w.err  = err;
      w.data = data;
      exp_wb_q.push_back(w);
   endtask

   // Counts negedges from the strobe cycle until ack/err; returns at posedge+1.
   task automatic wait_term(input string name, input int start, input int lo, input int hi);
      int cnt;
      bit seen;
      cnt  = start;
      seen = 1'b0;
      while (!seen && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (wb_ack_o || wb_err_o) seen = 1'b1;
      end
      n_vec++;
      if (!seen || cnt < lo || cnt > hi) begin
         n_err++;
         $display("FAIL %s_latency: got %0d cycles (seen=%0b), required %0d..%0d", name, cnt, seen, lo, hi);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit       found;
      mem_req_t r;
      rstn      = 1'b0;
      wb_cyc_i  = 1'b0;
      wb_stb_i  = 1'b0;
      wb_we_i   = 1'b0;
      wb_addr_i = '0;
      wb_data_i = '0;
      wb_sel_i  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack",       wb_ack_o,       0);
      check("rst_err",       wb_err_o,       0);
      check("rst_data",      wb_data_o,      0);
      check("rst_req_valid", mem_req_valid,  0);
      check("rst_resp_rdy",  mem_resp_ready, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Read, ready immediate, response after 3 cycles
      cfg_resp_delay = 3;
      cfg_rdata      = 32'hDEAD_BEEF;
      drive(1'b0, 32'h1000_0004, 32'h0, 4'hF);
      expect_wb(1'b0, 32'hDEAD_BEEF);
      wait_term("rd_basic", 0, 7, 7);
      release_bus();

      // Write; slave returns junk data which must not reach wb_data_o
      cfg_resp_delay = 0;
      cfg_rdata      = 32'h5555_5555;
      drive(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
      expect_wb(1'b0, 32'hDEAD_BEEF);
      wait_term("wr_basic", 0, 4, 4);

      // Back-to-back: strobe stays high into the IDLE cycle after ACK
      cfg_rdata = 32'h2424_2424;
      drive(1'b0, 32'h0000_0024, 32'h0, 4'hF);
      expect_wb(1'b0, 32'h2424_2424);
      wait_term("b2b", 0, 4, 4);
      release_bus();

      // Ready held low for 5 cycles
      cfg_ready_delay = 5;
      cfg_rdata       = 32'hCAFE_F00D;
      drive(1'b0, 32'h0000_0100, 32'h0, 4'hF);
      r.req_type  = REQ_READ;
      r.req_paddr = 32'h0000_0100;
      r.req_data  = 32'h0;
      r.req_mask  = 4'hF;
      expect_wb(1'b0, 32'hCAFE_F00D);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid",  mem_req_valid,       1);
         check("stall_fields", mem_req,             r);
         check("stall_noterm", wb_ack_o | wb_err_o, 0);
      end
      wait_term("stall", 6, 9, 9);
      cfg_ready_delay = 0;
      release_bus();

      // cyc dropped in RESP: response consumed, no ack/err
      cfg_resp_delay = 2;
      cfg_rdata      = 32'hA5A5_A5A5;
      drive(1'b0, 32'h0000_0030, 32'h0, 4'hF);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 release_bus();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (mem_resp_valid && mem_resp_ready) found = 1'b1;
      end
      check("abort_resp_consumed", found, 1);
      @(negedge clk);
      check("abort_no_ack",     wb_ack_o,       0);
      check("abort_no_err",     wb_err_o,       0);
      check("abort_idle_rdy",   mem_resp_ready, 0);
      check("abort_idle_valid", mem_req_valid,  0);
      @(posedge clk);
      #1;
      cfg_resp_delay = 0;
      cfg_rdata      = 32'h0BAD_F00D;
      drive(1'b0, 32'h0000_0040, 32'h0, 4'hF);
      expect_wb(1'b0, 32'h0BAD_F00D);
      wait_term("after_abort", 0, 4, 4);
      release_bus();

      // Timeout with a late response drained at RESP-count 12
      cfg_resp_delay = 11;
      cfg_rdata      = 32'hBAAD_BAAD;
      drive(1'b0, 32'h0000_0050, 32'h0, 4'hF);
      expect_wb(1'b1, 32'h0);
      wait_term("timeout", 0, 10, 11);
      drive(1'b0, 32'h0000_0060, 32'h0, 4'hF);
      expect_wb(1'b0, 32'h600D_1DEA);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (mem_resp_valid && mem_resp_ready) found = 1'b1;
         else check("drain_no_req", mem_req_valid, 0);
      end
      check("drain_resp_consumed", found, 1);
      cfg_resp_delay = 0;
      cfg_rdata      = 32'h600D_1DEA;
      @(negedge clk);
      check("drain_discard", wb_data_o,      32'h0BAD_F00D);
      check("drain_to_idle", mem_resp_ready, 0);
      wait_term("post_drain", 1, 4, 4);
      release_bus();

      // Asynchronous reset while in RESP
      cfg_resp_delay = 1000;
      drive(1'b0, 32'h0000_0070, 32'h0, 4'hF);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_resp_rdy", mem_resp_ready, 1);
      #1 rstn = 1'b0;
      #1;
      check("arst_ack",        wb_ack_o,       0);
      check("arst_err",        wb_err_o,       0);
      check("arst_data",       wb_data_o,      0);
      check("arst_req_valid",  mem_req_valid,  0);
      check("arst_resp_rdy",   mem_resp_ready, 0);
      check("arst_req_fields", mem_req,        0);
      release_bus();
      #9 rstn = 1'b1;
      @(posedge clk);
      #1;
      cfg_resp_delay = 0;
      cfg_rdata      = 32'h1357_9BDF;
      drive(1'b0, 32'h0000_0080, 32'h0, 4'hF);
      expect_wb(1'b0, 32'h1357_9BDF);
      wait_term("post_reset", 0, 4, 4);
      release_bus();

      repeat (3) @(posedge clk);
      check("exp_req_drained", exp_req_q.size(), 0);
      check("exp_wb_drained",  exp_wb_q.size(),  0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/wb2mem.md
Name: wb2mem

Overview:
- Wishbone classic slave that converts each single Wishbone cycle into one mem_req / mem_resp transaction toward a mem-interface slave (SRAM controller, peripheral bus, etc.).
- Lets Wishbone-master peripherals, such as a debug or DMA engine, reach memory on the core's mem interface.
- Carries one outstanding transaction, no pipelining.
- Adds a response timeout that returns a Wishbone error instead of hanging the bus.

Parameters:
- N_AW, 32, address width.
- N_DW, 32, data width.
- N_DM, N_DW/8, byte-select width.
- TIMEOUT, 256, maximum cycles spent in RESP before error. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active low.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_addr_i  in  N_AW  address.
- wb_data_i  in  N_DW  write data.
- wb_sel_i  in  N_DM  byte selects.
- wb_ack_o  out  1  acknowledge, one-cycle pulse.
- wb_err_o  out  1  error (timeout), one-cycle pulse.
- wb_data_o  out  N_DW  read data.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  request accepted.
- mem_req  out  mem_req_t  fields req_type, req_paddr, req_data, req_mask.
- mem_resp_valid  in  1  response valid.
- mem_resp_ready  out  1  response accepted.
- mem_resp  in  mem_resp_t  fields resp_type, resp_data.

Behaviour:
- Reset: all outputs 0, state IDLE, abort flag 0, timeout counter 0.
- Reset is asynchronous. Asserting rstn low mid-transaction returns to IDLE immediately; any in-flight response is not tracked.

States:
- IDLE: if wb_cyc_i && wb_stb_i at a clock edge, register the request fields and go to REQ. Field mapping:
  - req_type = wb_we_i ? REQ_WRITE : REQ_READ
  - req_paddr = wb_addr_i
  - req_data = wb_data_i
  - req_mask = wb_sel_i
- REQ: mem_req_valid = 1.
  - mem_req fields are held stable until mem_req_valid && mem_req_ready; valid is never retracted.
  - On that handshake go to RESP.
- RESP: mem_resp_ready = 1. The timeout counter increments each cycle.
  - On mem_resp_valid: capture resp_data into wb_data_o (reads only; writes leave wb_data_o unchanged).
  - Then go to ACK, or to IDLE without ack if the abort flag is set.
- ACK: wb_ack_o = 1 for exactly this cycle, then go to IDLE.
- DRAIN: mem_resp_ready = 1. Wishbone requests are ignored. On mem_resp_valid, discard the response and go to IDLE.

Latency:
- Strobe sampled at edge N gives mem_req_valid from cycle N+1.
- A response accepted at edge M gives wb_ack_o during cycle M+1.
- Minimum turnaround is 4 cycles from strobe to ack.

Abort:
- If wb_cyc_i is low in REQ or RESP, set the abort flag.
- The mem transaction still completes: the request is not retracted and the response is consumed.
- No ack or err is issued for an aborted transaction. The flag clears on return to IDLE.

Timeout (TIMEOUT > 0):
- When the counter reaches TIMEOUT in RESP with no response, pulse wb_err_o for 1 cycle (suppressed if aborted) and go to DRAIN.
- The counter clears on entering RESP.
- A response and the timeout in the same cycle: the response wins, normal ACK.

Simultaneous events and boundaries:
- wb_ack_o and wb_err_o are never high together.
- Back-to-back: if stb is still high in the IDLE cycle after ACK, it is treated as a new transaction.
- The mem_resp.resp_type mismatch is ignored.
- The counter width is sized by $clog2(TIMEOUT+1) and does not wrap.

Test Plan:
- Read at 0x1000_0004, ready immediate, resp 0xDEADBEEF after 3 cycles -> req_type=REQ_READ, paddr=0x1000_0004; wb_ack_o single pulse with wb_data_o=0xDEADBEEF.
- Write 0x12345678, sel=4'b0011, addr 0x20 -> req_type=REQ_WRITE, req_data=0x12345678, req_mask=4'b0011; one ack; wb_data_o unchanged.
- mem_req_ready held low 5 cycles -> mem_req_valid stays 1 and fields stay stable for all 5 cycles; no ack until response.
- wb_cyc_i dropped during RESP, response 2 cycles later -> response consumed (mem_resp_ready=1), no ack/err, IDLE; a following read at 0x40 completes normally.
- TIMEOUT=8, no response -> wb_err_o pulses in RESP cycle 8, state DRAIN; a late response at cycle 12 is consumed; no ack; a new stb during DRAIN is not served until IDLE.
- rstn low for 1 cycle while in RESP -> all outputs 0 immediately, IDLE; a next read completes with normal 4-cycle latency.
